// File: rtl/coe_wr_pack_pkg.sv
// Shared encodings for the CABAC coefficient write path: component types, CABAC sel codes,
// coefficient-to-slot permutation and the slot-to-lane placement.
package coe_wr_pack_pkg;

  localparam int unsigned COEFF_WIDTH = 16;

  // Component type as delivered by rec/quant; 2'd3 is illegal.
  localparam logic [1:0] TYPE_Y = 2'd0;
  localparam logic [1:0] TYPE_U = 2'd1;
  localparam logic [1:0] TYPE_V = 2'd2;

  localparam logic [1:0] CABAC_Y = 2'd2;
  localparam logic [1:0] CABAC_U = 2'd1;
  localparam logic [1:0] CABAC_V = 2'd0;

  // Slot s of a half carries input coefficient COEFF_PERM[s].
  localparam int unsigned COEFF_PERM [16] = '{0, 4, 1, 5, 8, 12, 9, 13,
                                              2, 6, 3, 7, 10, 14, 11, 15};

  typedef enum logic [1:0] {StEmpty, StHalf, StOut} state_e;

  // Lane (MSB-first) holding slot s of the 32-slot word.
  function automatic int unsigned lane_of_slot(input int unsigned s);
    if (s < 16) return 8 * (s / 4) + s % 4;
    else        return 8 * ((s - 16) / 4) + 4 + s % 4;
  endfunction

  // Inverse of the read translator's sel map; illegal type falls back to Y.
  function automatic logic [1:0] cabac_sel(input logic [1:0] t);
    unique case (t)
      TYPE_U:  return CABAC_U;
      TYPE_V:  return CABAC_V;
      default: return CABAC_Y;
    endcase
  endfunction

endpackage

// File: rtl/coe_wr_lane_map.sv
// Places one 4x4 block of coefficients into the hi or lo half of a 32-lane word;
// lanes of the other half are zero.
module coe_wr_lane_map
  import coe_wr_pack_pkg::*;
#(
  parameter int unsigned COEFF_W = COEFF_WIDTH
) (
  input  logic [16*COEFF_W-1:0] dat_i,
  input  logic                  lo_i,
  output logic [32*COEFF_W-1:0] word_o
);

  for (genvar s = 0; s < 16; s++) begin : g_slot
    localparam int unsigned K   = COEFF_PERM[s];
    localparam int unsigned LHI = lane_of_slot(s);
    localparam int unsigned LLO = lane_of_slot(s + 16);

    assign word_o[(31-LHI)*COEFF_W +: COEFF_W] = lo_i ? '0 : dat_i[(15-K)*COEFF_W +: COEFF_W];
    assign word_o[(31-LLO)*COEFF_W +: COEFF_W] = lo_i ? dat_i[(15-K)*COEFF_W +: COEFF_W] : '0;
  end

endmodule

// File: rtl/coe_wr_pack.sv
// Pairs vertically adjacent 4x4 coefficient blocks into one 32-coefficient buffer word
// and writes it through a valid/ready port with a per-half mask.
module coe_wr_pack
  import coe_wr_pack_pkg::*;
#(
  parameter int unsigned COEFF_W = COEFF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  blk_val_i,
  output logic                  blk_rdy_o,
  input  logic [1:0]            blk_sel_i,
  input  logic [3:0]            blk_4x4_x_i,
  input  logic [3:0]            blk_4x4_y_i,
  input  logic [16*COEFF_W-1:0] blk_dat_i,
  input  logic                  blk_flush_i,
  output logic                  coe_wr_ena_o,
  input  logic                  coe_wr_rdy_i,
  output logic [1:0]            coe_wr_sel_o,
  output logic [6:0]            coe_wr_addr_o,
  output logic [1:0]            coe_wr_msk_o,
  output logic [32*COEFF_W-1:0] coe_wr_dat_o
);

  state_e state_q, state_d;

  logic [16*COEFF_W-1:0] held_dat_q;
  logic [1:0]            held_sel_q;
  logic [3:0]            held_x_q;
  logic [2:0]            held_yh_q;

  logic [32*COEFF_W-1:0] held_word, blk_word;
  logic                  partner;

  logic                  hold_ld, out_ld;
  logic [1:0]            out_sel_d, out_msk_d;
  logic [6:0]            out_addr_d;
  logic [32*COEFF_W-1:0] out_dat_d;

  coe_wr_lane_map #(.COEFF_W(COEFF_W)) u_map_held (
    .dat_i  (held_dat_q),
    .lo_i   (1'b0),
    .word_o (held_word)
  );

  coe_wr_lane_map #(.COEFF_W(COEFF_W)) u_map_blk (
    .dat_i  (blk_dat_i),
    .lo_i   (blk_4x4_y_i[0]),
    .word_o (blk_word)
  );

  // Only y[0]=0 blocks are ever held, so the held y[0] test is implicit.
  assign partner = blk_4x4_y_i[0] && (blk_sel_i == held_sel_q) &&
                   (blk_4x4_x_i == held_x_q) && (blk_4x4_y_i[3:1] == held_yh_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (blk_val_i) state_d = (!blk_4x4_y_i[0] && !blk_flush_i) ? StHalf : StOut;
      StHalf:  if (blk_val_i || blk_flush_i) state_d = StOut;
      StOut:   if (coe_wr_rdy_i) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    blk_rdy_o    = 1'b0;
    coe_wr_ena_o = 1'b0;
    hold_ld      = 1'b0;
    out_ld       = 1'b0;
    out_msk_d    = 2'b00;
    out_dat_d    = blk_word;
    out_sel_d    = cabac_sel(blk_sel_i);
    out_addr_d   = {blk_4x4_y_i[3:1], blk_4x4_x_i};
    unique case (state_q)
      StEmpty: begin
        blk_rdy_o = 1'b1;
        if (blk_val_i) begin
          if (!blk_4x4_y_i[0] && !blk_flush_i) begin
            hold_ld = 1'b1;
          end else begin
            out_ld    = 1'b1;
            out_msk_d = blk_4x4_y_i[0] ? 2'b01 : 2'b10;
          end
        end
      end
      StHalf: begin
        blk_rdy_o  = blk_val_i && partner;
        out_sel_d  = cabac_sel(held_sel_q);
        out_addr_d = {held_yh_q, held_x_q};
        // A partner beats a simultaneous flush.
        if (blk_val_i && partner) begin
          out_ld    = 1'b1;
          out_msk_d = 2'b11;
          out_dat_d = held_word | blk_word;
        end else if (blk_val_i || blk_flush_i) begin
          out_ld    = 1'b1;
          out_msk_d = 2'b10;
          out_dat_d = held_word;
        end
      end
      StOut:   coe_wr_ena_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_dat_q <= '0;
      held_sel_q <= TYPE_Y;
      held_x_q   <= '0;
      held_yh_q  <= '0;
    end else if (hold_ld) begin
      held_dat_q <= blk_dat_i;
      held_sel_q <= blk_sel_i;
      held_x_q   <= blk_4x4_x_i;
      held_yh_q  <= blk_4x4_y_i[3:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coe_wr_sel_o  <= CABAC_Y;
      coe_wr_addr_o <= '0;
      coe_wr_msk_o  <= '0;
      coe_wr_dat_o  <= '0;
    end else if (out_ld) begin
      coe_wr_sel_o  <= out_sel_d;
      coe_wr_addr_o <= out_addr_d;
      coe_wr_msk_o  <= out_msk_d;
      coe_wr_dat_o  <= out_dat_d;
    end
  end

endmodule
